alu_arbiter: RTL and testbench

Sequencer and two-way round-robin arbiter for the shared 4-bit combinational ALU (operands a[3:0], b[3:0], opcode s[2:0], result y[7:0]). Two requesters submit operand/opcode triples through valid/ready handshakes. The block grants one requester at a time, drives the latched operands onto the ALU, and captures the 8-bit result into a register. It returns the result on a per-requester response handshake and counts completed operations.

---
 rtl/alu_arbiter.sv | 93 +++++++++
 tb/tb_alu_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-way round-robin arbiter and sequencer for a shared combinational 4-bit ALU
module alu_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic [3:0] req_a0,
    input  logic [3:0] req_a1,
    input  logic [3:0] req_b0,
    input  logic [3:0] req_b1,
    input  logic [2:0] req_s0,
    input  logic [2:0] req_s1,
    output logic [1:0] req_ready,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [7:0] rsp_y,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_s,
    input  logic [7:0] alu_y,
    output logic       busy,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   grant;
    logic   winner;

    // On a tie the requester that was not served last wins.
    always_comb begin
        winner = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        busy      = 1'b0;
        if (!rst) begin
            if (state == IDLE && req_valid != 2'b00) begin
                req_ready[winner] = 1'b1;
            end
            if (state == RESP) begin
                rsp_valid[grant] = 1'b1;
            end
            busy = (state != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_s      <= 3'd0;
            rsp_y      <= 8'd0;
            op_count   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        grant <= winner;
                        alu_a <= winner ? req_a1 : req_a0;
                        alu_b <= winner ? req_b1 : req_b0;
                        alu_s <= winner ? req_s1 : req_s0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU has had the whole EXEC cycle to settle.
                    rsp_y <= alu_y;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready[grant]) begin
                        last_grant <= grant;
                        op_count   <= op_count + 8'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [3:0] req_a0, req_a1, req_b0, req_b1;
    logic [2:0] req_s0, req_s1;
    logic [1:0] req_ready, rsp_valid, rsp_ready;
    logic [7:0] rsp_y, alu_y, op_count;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_s;
    logic       busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Reference ALU standing in for the shared combinational unit.
    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        case (s)
            3'd0:    alu_f = {4'd0, a} + {4'd0, b};
            3'd1:    alu_f = {4'd0, a} - {4'd0, b};
            3'd2:    alu_f = {4'd0, a & b};
            3'd3:    alu_f = {4'd0, a | b};
            3'd4:    alu_f = {4'd0, a ^ b};
            3'd5:    alu_f = a * b;
            3'd6:    alu_f = {4'd0, a};
            default: alu_f = {4'd0, b};
        endcase
    endfunction

    assign alu_y = alu_f(alu_a, alu_b, alu_s);

    alu_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_s0(req_s0), .req_s1(req_s1), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
        .busy(busy), .op_count(op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
        req_a0 = 4'd9;  req_b0 = 4'd3;  req_s0 = 3'd0;
        req_a1 = 4'd13; req_b1 = 4'd11; req_s1 = 3'd3;

        // Reset with both requesters valid
        repeat (2) tick();
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_a", alu_a, 4'd0);
        chk("rst_alu_b", alu_b, 4'd0);
        chk("rst_alu_s", alu_s, 3'd0);
        chk("rst_rsp_y", rsp_y, 8'd0);
        chk("rst_op_count", op_count, 8'd0);
        rst = 1'b0; req_valid = 2'b00;

        // Single op from requester 0: 9 + 3 = 12
        req_valid = 2'b01; rsp_ready = 2'b11;
        #1 chk("single_req_ready", req_ready, 2'b01);
        chk("single_busy_T", busy, 1'b0);
        tick();
        req_valid = 2'b00;
        chk("single_alu_a", alu_a, 4'd9);
        chk("single_alu_b", alu_b, 4'd3);
        chk("single_alu_s", alu_s, 3'd0);
        chk("single_busy_exec", busy, 1'b1);
        chk("single_ready_exec", req_ready, 2'b00);
        tick();
        chk("single_rsp_valid", rsp_valid, 2'b01);
        chk("single_rsp_y", rsp_y, 8'd12);
        tick();
        chk("single_op_count", op_count, 8'd1);
        chk("single_idle_busy", busy, 1'b0);

        // Reset so requester 0 wins the first tie
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Tie and fairness: grants alternate 0,1,0,1
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1 chk("tie_req_ready", req_ready, (i % 2) ? 2'b10 : 2'b01);
            tick();
            chk("tie_alu_a", alu_a, (i % 2) ? 4'd13 : 4'd9);
            tick();
            chk("tie_rsp_valid", rsp_valid, (i % 2) ? 2'b10 : 2'b01);
            chk("tie_rsp_y", rsp_y, (i % 2) ? 8'd15 : 8'd12);
            tick();
        end
        chk("tie_op_count", op_count, 8'd4);
        req_valid = 2'b00;

        // Back-pressure and wrong-port ready: requester 1, 7 ^ 5 = 2
        req_a1 = 4'd7; req_b1 = 4'd5; req_s1 = 3'd4; rsp_ready = 2'b00;
        req_valid = 2'b10;
        #1 chk("bp_req_ready", req_ready, 2'b10);
        tick();
        tick();
        chk("bp_rsp_valid0", rsp_valid, 2'b10);
        chk("bp_rsp_y0", rsp_y, 8'd2);
        req_valid = 2'b11; req_a1 = 4'd0; rsp_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rsp_valid", rsp_valid, 2'b10);
            chk("bp_rsp_y", rsp_y, 8'd2);
            chk("bp_req_ready", req_ready, 2'b00);
            chk("bp_busy", busy, 1'b1);
            chk("wrong_port_count", op_count, 8'd4);
        end
        rsp_ready = 2'b10; req_valid = 2'b00;
        tick();
        chk("bp_done_count", op_count, 8'd5);
        chk("bp_done_rsp_valid", rsp_valid, 2'b00);
        chk("bp_done_busy", busy, 1'b0);

        // Reset in EXEC abandons the op
        rsp_ready = 2'b11; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        chk("mid_busy_exec", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 chk("mid_busy", busy, 1'b0);
        chk("mid_rsp_valid", rsp_valid, 2'b00);
        chk("mid_op_count", op_count, 8'd0);
        chk("mid_alu_a", alu_a, 4'd0);
        tick();
        chk("mid_rsp_valid_next", rsp_valid, 2'b00);
        chk("mid_op_count_next", op_count, 8'd0);

        // 256 back-to-back ops: counter wraps
        req_valid = 2'b01;
        repeat (255 * 3) tick();
        chk("wrap_255", op_count, 8'd255);
        repeat (3) tick();
        chk("wrap_0", op_count, 8'd0);
        req_valid = 2'b00;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
